mips_cpu_regfile_mp: RTL and testbench

Parametrised successor to mips_cpu_registers: a general-purpose register file with NUM_RD asynchronous read ports, one synchronous write port, optional write-to-read bypass and a per-register pending-write scoreboard. The scoreboard tracks outstanding load destinations so the decode stage can stall on RAW hazards. Sits between decode (read/claim) and writeback (write) in the MIPS32 core.

---
 rtl/mips_cpu_regfile_pkg.sv | 23 ++
 rtl/mips_cpu_regfile_mp_scoreboard.sv | 58 +++++
 rtl/mips_cpu_regfile_mp.sv | 76 +++++++
 tb/tb_mips_cpu_regfile_mp.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_regfile_pkg.sv
// Shared constants and bus helpers for the multi-port MIPS register file.
// Imported by the scoreboard and the register-file top level.
package mips_cpu_regfile_pkg;

   localparam int REG_ZERO       = 0;
   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;
   localparam int BUS_MAX        = 1024;
   localparam int FIELD_MAX      = 64;

   // Returns field idx of a packed bus whose fields are width bits wide;
   // callers zero-extend the bus to BUS_MAX and size-cast the result.
   function automatic logic [FIELD_MAX-1:0] port_field(input logic [BUS_MAX-1:0] bus,
                                                       input int idx, input int width);
      logic [BUS_MAX-1:0]   shifted;
      logic [FIELD_MAX-1:0] field;
      shifted = bus >> (idx * width);
      field   = shifted[FIELD_MAX-1:0];
      field   = field & ~({FIELD_MAX{1'b1}} << width);
      return field;
   endfunction

endpackage

// File: rtl/mips_cpu_regfile_mp_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus an incrementally
// maintained count of busy registers. Register 0 is never marked busy.
module mips_cpu_scoreboard
   import mips_cpu_regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_RD     = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         write,
   input  logic [ADDR_WIDTH-1:0]        wr_addr,
   input  logic                         claim,
   input  logic [ADDR_WIDTH-1:0]        claim_addr,
   input  logic                         flush,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
   output logic [NUM_RD-1:0]            busy_raw,
   output logic [ADDR_WIDTH:0]          pending_count
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CW    = ADDR_WIDTH + 1;

   logic [DEPTH-1:0] busy;
   logic             do_set, do_clr, inc, dec;

   // A same-address claim overrides the write's clear, so it never decrements.
   always_comb begin
      do_set = claim && (claim_addr != ADDR_WIDTH'(REG_ZERO));
      do_clr = write && (wr_addr != ADDR_WIDTH'(REG_ZERO));
      inc    = do_set && !busy[claim_addr];
      dec    = do_clr && busy[wr_addr] && !(do_set && (claim_addr == wr_addr));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy          <= '0;
         pending_count <= '0;
      end else if (flush) begin
         busy          <= '0;
         pending_count <= '0;
      end else begin
         if (do_clr) busy[wr_addr]    <= 1'b0;
         if (do_set) busy[claim_addr] <= 1'b1;
         pending_count <= pending_count + CW'(inc) - CW'(dec);
      end
   end

   always_comb begin
      busy_raw = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         logic [ADDR_WIDTH-1:0] a;
         a           = ADDR_WIDTH'(port_field(BUS_MAX'(rd_addr), i, ADDR_WIDTH));
         busy_raw[i] = busy[a];
      end
   end

endmodule

// File: rtl/mips_cpu_regfile_mp.sv
// Multi-port general-purpose register file with optional write-to-read bypass
// and a pending-write scoreboard for decode-stage RAW stalls.
module mips_cpu_regfile_mp
   import mips_cpu_regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int NUM_RD     = 2,
   parameter int BYPASS     = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         write,
   input  logic [ADDR_WIDTH-1:0]        wrAddr,
   input  logic [DATA_WIDTH-1:0]        wrData,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rdAddr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rdData,
   output logic [NUM_RD-1:0]            rdBusy,
   input  logic                         claim,
   input  logic [ADDR_WIDTH-1:0]        claimAddr,
   input  logic                         flush,
   output logic [ADDR_WIDTH:0]          pendingCount
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [NUM_RD-1:0]     busy_raw;

   mips_cpu_scoreboard #(
      .ADDR_WIDTH(ADDR_WIDTH),
      .NUM_RD    (NUM_RD)
   ) u_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .write        (write),
      .wr_addr      (wrAddr),
      .claim        (claim),
      .claim_addr   (claimAddr),
      .flush        (flush),
      .rd_addr      (rdAddr),
      .busy_raw     (busy_raw),
      .pending_count(pendingCount)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) regs[k] <= '0;
      end else if (write && (wrAddr != ADDR_WIDTH'(REG_ZERO))) begin
         regs[wrAddr] <= wrData;
      end
   end

   // Bypassed ports see the incoming write; busy drops unless re-claimed now.
   always_comb begin
      rdData = '0;
      rdBusy = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         logic [ADDR_WIDTH-1:0] a;
         logic [DATA_WIDTH-1:0] d;
         logic                  b;
         logic                  hit;
         a   = ADDR_WIDTH'(port_field(BUS_MAX'(rdAddr), i, ADDR_WIDTH));
         hit = (BYPASS != 0) && write && (wrAddr == a);
         d   = '0;
         b   = 1'b0;
         if (a != ADDR_WIDTH'(REG_ZERO)) begin
            d = hit ? wrData : regs[a];
            b = busy_raw[i] && !(hit && !(claim && (claimAddr == a)));
         end
         rdData[i*DATA_WIDTH +: DATA_WIDTH] = d;
         rdBusy[i]                          = b;
      end
   end

endmodule

// File: tb/tb_mips_cpu_regfile_mp.sv
// Scoreboard-driven bench for mips_cpu_regfile_mp, with a bypassing and a
// non-bypassing instance sharing the same stimulus.
module tb_mips_cpu_regfile_mp;

   logic        clk = 1'b0;
   logic        reset, write, claim, flush;
   logic [4:0]  wrAddr, claimAddr;
   logic [31:0] wrData;
   logic [9:0]  rdAddr;
   logic [63:0] rdData, nb_rdData;
   logic [1:0]  rdBusy, nb_rdBusy;
   logic [5:0]  pendingCount, nb_pendingCount;

   always #5 clk = ~clk;

   mips_cpu_regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
      .rdAddr(rdAddr), .rdData(rdData), .rdBusy(rdBusy), .claim(claim),
      .claimAddr(claimAddr), .flush(flush), .pendingCount(pendingCount));

   mips_cpu_regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .write(write), .wrAddr(wrAddr), .wrData(wrData),
      .rdAddr(rdAddr), .rdData(nb_rdData), .rdBusy(nb_rdBusy), .claim(claim),
      .claimAddr(claimAddr), .flush(flush), .pendingCount(nb_pendingCount));

   typedef struct {
      string       tag;
      int          sel;
      logic [63:0] exp;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] mregs [32];
   logic [31:0] mbusy;

   function automatic logic [63:0] observe(input int sel);
      case (sel)
         0: return {32'd0, rdData[31:0]};
         1: return {32'd0, rdData[63:32]};
         2: return {62'd0, rdBusy};
         3: return {58'd0, pendingCount};
         4: return {32'd0, nb_rdData[63:32]};
         5: return {62'd0, nb_rdBusy};
         default: return {58'd0, nb_pendingCount};
      endcase
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input int sel, input logic [63:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      q.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         check(e.tag, observe(e.sel), e.exp);
      end
   endtask

   function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 32'd0;
      if (byp && write && wrAddr == a) return wrData;
      return mregs[a];
   endfunction

   function automatic logic m_busy(input logic [4:0] a, input bit byp);
      if (a == 5'd0) return 1'b0;
      if (byp && write && wrAddr == a && !(claim && claimAddr == a)) return 1'b0;
      return mbusy[a];
   endfunction

   // Apply one cycle of inputs and queue model expectations for the
   // combinational outputs before the edge.
   task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra0,
                        input logic [4:0] ra1, input logic c, input logic [4:0] ca,
                        input logic f);
      reset = r; write = w; wrAddr = wa; wrData = wd;
      rdAddr = {ra1, ra0}; claim = c; claimAddr = ca; flush = f;
      #1;
      if (!r) begin
         push("m_rd0",  0, {32'd0, m_rd(ra0, 1'b1)});
         push("m_rd1",  1, {32'd0, m_rd(ra1, 1'b1)});
         push("m_busy", 2, {62'd0, m_busy(ra1, 1'b1), m_busy(ra0, 1'b1)});
         push("m_cnt",  3, {58'd0, 6'($countones(mbusy))});
         push("m_nb_rd1",  4, {32'd0, m_rd(ra1, 1'b0)});
         push("m_nb_busy", 5, {62'd0, m_busy(ra1, 1'b0), m_busy(ra0, 1'b0)});
         push("m_nb_cnt",  6, {58'd0, 6'($countones(mbusy))});
      end
      drain();
   endtask

   task automatic commit();
      @(posedge clk);
      if (reset) begin
         for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
         mbusy = 32'd0;
      end else begin
         if (write && wrAddr != 5'd0) mregs[wrAddr] = wrData;
         if (flush) mbusy = 32'd0;
         else begin
            if (write && wrAddr != 5'd0) mbusy[wrAddr] = 1'b0;
            if (claim && claimAddr != 5'd0) mbusy[claimAddr] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                       input logic c, input logic [4:0] ca, input logic f);
      drive(1'b0, w, wa, wd, 5'd0, 5'd0, c, ca, f);
      commit();
   endtask

   task automatic probe(input logic [4:0] ra0, input logic [4:0] ra1);
      drive(1'b0, 1'b0, 5'd0, 32'd0, ra0, ra1, 1'b0, 5'd0, 1'b0);
   endtask

   initial begin
      for (int k = 0; k < 32; k++) mregs[k] = 32'd0;
      mbusy = 32'd0;
      @(posedge clk); #1;

      // Reset wins over a simultaneous write
      drive(1'b1, 1'b1, 5'd3, 32'd7, 5'd3, 5'd3, 1'b0, 5'd0, 1'b0);
      commit();
      probe(5'd3, 5'd3);
      push("rst_rd3", 0, 64'd0);
      push("rst_cnt", 3, 64'd0);
      push("rst_busy", 2, 64'd0);
      drain();

      // Register 0 ignores writes
      step(1'b1, 5'd0, 32'd5, 1'b0, 5'd0, 1'b0);
      step(1'b1, 5'd10, 32'd45, 1'b0, 5'd0, 1'b0);
      probe(5'd0, 5'd10);
      push("rd_zero", 0, 64'd0);
      push("rd10_p1", 1, 64'd45);
      drain();
      probe(5'd10, 5'd0);
      push("rd10_p0", 0, 64'd45);
      drain();

      // Same-cycle bypass vs. array-only read
      drive(1'b0, 1'b1, 5'd12, 32'd35, 5'd0, 5'd12, 1'b0, 5'd0, 1'b0);
      push("byp_rd12", 1, 64'd35);
      push("nobyp_rd12_pre", 4, 64'd0);
      drain();
      commit();
      probe(5'd0, 5'd12);
      push("nobyp_rd12_post", 4, 64'd35);
      drain();

      // Claims, then write clears busy
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0);
      probe(5'd8, 5'd0);
      push("busy8", 2, 64'd1);
      push("cnt2", 3, 64'd2);
      drain();
      step(1'b1, 5'd8, 32'h1234, 1'b0, 5'd0, 1'b0);
      probe(5'd8, 5'd9);
      push("busy8_clr", 2, 64'd2);
      push("cnt1", 3, 64'd1);
      push("rd8", 0, 64'h1234);
      drain();

      // Claim and write to the same register: claim wins, data still stored
      step(1'b1, 5'd4, 32'd99, 1'b1, 5'd4, 1'b0);
      probe(5'd4, 5'd0);
      push("rd4", 0, 64'd99);
      push("busy4", 2, 64'd1);
      push("cnt_cw", 3, 64'd2);
      drain();

      // Flush drops a simultaneous claim; contents survive; reg 0 never claimed
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0);
      probe(5'd2, 5'd5);
      push("cnt5", 3, 64'd5);
      drain();
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 1'b1);
      probe(5'd6, 5'd2);
      push("flush_cnt", 3, 64'd0);
      push("flush_busy", 2, 64'd0);
      drain();
      probe(5'd4, 5'd10);
      push("flush_rd4", 0, 64'd99);
      push("flush_rd10", 1, 64'd45);
      drain();
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0);
      probe(5'd0, 5'd0);
      push("claim0_cnt", 3, 64'd0);
      drain();

      // Randomised traffic on a few registers to provoke collisions
      for (int n = 0; n < 400; n++) begin
         drive(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), $urandom,
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               1'($urandom_range(0, 15) == 0));
         commit();
      end
      probe(5'd1, 5'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
